// File: rtl/sha_256_padder.sv
// sha_256_padder
// Packs a byte stream into 512-bit SHA-256 message blocks and applies the
// standard padding (0x80, zero fill, 64-bit big-endian bit length). When a
// message ends too close to the end of a block, an extra length-only block
// is emitted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    message byte
//   in_valid   in_data is valid
//   in_last    current byte is the final byte of the message
//   in_ready   padder can accept a byte (FILL state only)
//   blk_data   padded block, bits [0:511], byte k at [8k:8k+7], MSB first
//   blk_valid  blk_data is valid
//   blk_first  block is the first of its message
//   blk_last   block is the final block of its message
//   blk_ready  downstream accepts the block
module sha_256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [0:511] blk_data,
  output logic         blk_valid,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ready
);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_X} state_t;

  state_t             state;
  logic [5:0]         idx;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic [1:0]         pad_pend;
  logic               first_pend;
  logic [0:511]       fill_data;
  logic [0:511]       x_data;
  logic [63:0]        len_fill;
  logic [63:0]        len_x;
  int unsigned        n;

  assign in_ready = (state == FILL);
  assign cnt_inc  = bit_cnt + LEN_W'(8);

  // fill_data: block register with the incoming byte written and, on the
  // final byte, padding applied. x_data: the extra length-only block.
  always_comb begin
    n        = 32'(idx) + 32'd1;
    len_fill = '0;
    len_fill[LEN_W-1:0] = cnt_inc;
    len_x    = '0;
    len_x[LEN_W-1:0] = bit_cnt;

    fill_data = blk_data;
    fill_data[{idx, 3'b000} +: 8] = in_data;
    if (in_last) begin
      for (int unsigned k = 0; k < 64; k++) begin
        if (k == n) begin
          fill_data[8*k +: 8] = 8'h80;
        end else if (k > n) begin
          if (k < 56)
            fill_data[8*k +: 8] = 8'h00;
          else if (n <= 55)
            fill_data[8*k +: 8] = len_fill[8*(63-k) +: 8];
          else
            fill_data[8*k +: 8] = 8'h00;
        end
      end
    end

    x_data = '0;
    x_data[0:7] = pad_pend[1] ? 8'h80 : 8'h00;
    for (int unsigned k = 56; k < 64; k++)
      x_data[8*k +: 8] = len_x[8*(63-k) +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      idx        <= '0;
      bit_cnt    <= '0;
      pad_pend   <= '0;
      first_pend <= 1'b1;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      blk_data   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            blk_data <= fill_data;
            bit_cnt  <= cnt_inc;
            if (in_last || idx == 6'd63) begin
              state      <= EMIT;
              idx        <= '0;
              blk_valid  <= 1'b1;
              blk_first  <= first_pend;
              first_pend <= 1'b0;
              if (!in_last) begin
                blk_last <= 1'b0;
                pad_pend <= 2'b00;
              end else if (n <= 55) begin
                blk_last <= 1'b1;
                pad_pend <= 2'b00;
              end else if (n <= 63) begin
                blk_last <= 1'b0;
                pad_pend <= 2'b01;
              end else begin
                blk_last <= 1'b0;
                pad_pend <= 2'b10;
              end
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pad_pend != 2'b00) begin
              state     <= EMIT_X;
              blk_data  <= x_data;
              blk_first <= 1'b0;
              blk_last  <= 1'b1;
            end else begin
              state     <= FILL;
              blk_valid <= 1'b0;
              blk_first <= 1'b0;
              blk_last  <= 1'b0;
              if (blk_last) begin
                bit_cnt    <= '0;
                first_pend <= 1'b1;
              end
            end
          end
        end
        EMIT_X: begin
          if (blk_ready) begin
            state      <= FILL;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            pad_pend   <= '0;
            bit_cnt    <= '0;
            first_pend <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_256_padder.sv
// tb_sha_256_padder
// Directed + randomized bench for sha_256_padder. Expected blocks come from
// padding the whole message with the standard SHA-256 rule and slicing the
// result into 64-byte blocks.
module tb_sha_256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [0:511] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0]   msg[$];
  logic [0:511] exp_q[$];

  sha_256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_msg(input int len, input bit zero);
    msg.delete();
    for (int i = 0; i < len; i++)
      msg.push_back(zero ? 8'h00 : 8'($urandom));
  endtask

  // Whole-message padding, then split into 64-byte blocks.
  task automatic build_model();
    logic [7:0]   pad[$];
    logic [63:0]  bl;
    logic [0:511] blk;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int j = 0; j < 8; j++) pad.push_back(bl[8*(7-j) +: 8]);
    exp_q.delete();
    for (int b = 0; b < pad.size() / 64; b++) begin
      blk = '0;
      for (int k = 0; k < 64; k++) blk[8*k +: 8] = pad[64*b + k];
      exp_q.push_back(blk);
    end
  endtask

  // mode 0: always valid/ready; 1: random gaps and backpressure;
  // 2: input always valid, each block held 5 cycles before ready.
  task automatic run_msg(input int mode);
    int  len, i, popped, nblk, avail, hold, cyc;
    bit  pending, r, v;
    build_model();
    len = msg.size();
    nblk = exp_q.size();
    i = 0; popped = 0; hold = 0; cyc = 0;
    while ((i < len || popped < nblk) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      avail   = (i == len) ? nblk : i / 64;
      pending = (avail > popped);
      chk("blk_valid", 512'(blk_valid), 512'(pending));
      chk("in_ready", 512'(in_ready), 512'(!pending));
      if (pending) begin
        chk("blk_data", blk_data, exp_q[popped]);
        chk("blk_first", 512'(blk_first), 512'(popped == 0));
        chk("blk_last", 512'(blk_last), 512'(popped == nblk - 1));
        case (mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom);
          default: r = (hold >= 5);
        endcase
        blk_ready = r;
        if (r) begin popped++; hold = 0; end
        else hold++;
      end else begin
        blk_ready = 1'($urandom);
      end
      if (i < len) begin
        v = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
        in_valid = v;
        in_data  = v ? msg[i] : 8'($urandom);
        in_last  = v ? (i == len - 1) : 1'($urandom);
        if (v && !pending) i++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end
    end
    chk("no_timeout", 512'(cyc < 4000), 512'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_blk_first"}, 512'(blk_first), 512'(0));
    chk({tag, "_blk_last"}, 512'(blk_last), 512'(0));
    chk({tag, "_blk_data"}, blk_data, 512'(0));
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_held");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // "abc"
    msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(0);
    // padding boundary lengths
    gen_msg(55, 1'b1); run_msg(0);
    gen_msg(56, 1'b0); run_msg(0);
    gen_msg(64, 1'b0); run_msg(0);
    gen_msg(64, 1'b0); run_msg(2);
    gen_msg(63, 1'b0); run_msg(2);
    gen_msg(1, 1'b0);  run_msg(1);
    gen_msg(119, 1'b0); run_msg(1);
    gen_msg(120, 1'b0); run_msg(1);
    gen_msg(128, 1'b0); run_msg(1);
    for (int t = 0; t < 10; t++) begin
      gen_msg(int'($urandom_range(1, 200)), 1'b0);
      run_msg(1);
    end

    // reset mid-message, then "abc"
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_msg_rst");
    @(negedge clk);
    rst = 1'b1;
    msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(0);

    // reset while a full block is being held by backpressure
    blk_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_blk_valid", 512'(blk_valid), 512'(1));
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_emit_rst");
    @(negedge clk);
    rst = 1'b1;
    gen_msg(70, 1'b0); run_msg(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
